mac_seq: RTL and testbench

Time-multiplexed, parametrised successor to the combinational local-field MAC in the p-bit Ising datapath. It computes one local field I = Σ J[row][j]·m[j] + h, with m[j] ∈ {−1,+1}, by streaming a stored J row LANES terms per cycle from an internal, writable weight RAM. It supports multiple rows, selectable overflow behaviour and a start/ready/out_valid handshake. It sits between the spin register and the beta/activation stage; one instance can serve several p-bits in turn.

---
 rtl/mac_seq_if.sv | 36 +++
 rtl/mac_seq.sv | 131 +++++++++++++
 tb/tb_mac_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mac_seq_if.sv
// Bus bundle for mac_seq: weight-RAM write port, start/ready request and result.
// The master drives requests and weights; the slave (the engine) returns results.
interface mac_seq_if #(
  parameter int N_SPINS  = 16,
  parameter int LANES    = 4,
  parameter int N_ROWS   = 16,
  parameter int W_BITS   = 8,
  parameter int H_BITS   = 8,
  parameter int ACC_BITS = 16
);
  localparam int BEATS = N_SPINS / LANES;
  localparam int AW    = $clog2(N_ROWS * BEATS);
  localparam int RW    = $clog2(N_ROWS);

  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic [LANES*W_BITS-1:0]   wr_data;
  logic                      start;
  logic [RW-1:0]             row;
  logic [N_SPINS-1:0]        m_in;
  logic [H_BITS-1:0]         h_in;
  logic                      ready;
  logic                      out_valid;
  logic [ACC_BITS-1:0]       out;
  logic                      ovf;

  modport master (
    output wr_en, wr_addr, wr_data, start, row, m_in, h_in,
    input  ready, out_valid, out, ovf
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, row, m_in, h_in,
    output ready, out_valid, out, ovf
  );
endinterface

// File: rtl/mac_seq.sv
// Time-multiplexed local-field MAC: streams one stored J row LANES terms per
// cycle, adds the bias and returns a clamped or wrapped signed field.
module mac_seq #(
  parameter int N_SPINS  = 16,
  parameter int LANES    = 4,
  parameter int N_ROWS   = 16,
  parameter int W_BITS   = 8,
  parameter int H_BITS   = 8,
  parameter int ACC_BITS = 16,
  parameter int SATURATE = 1
) (
  input  logic    clk,
  input  logic    rst,
  mac_seq_if.slave bus
);
  localparam int BEATS = N_SPINS / LANES;
  localparam int AW    = $clog2(N_ROWS * BEATS);
  localparam int RW    = $clog2(N_ROWS);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TW    = W_BITS + 1;
  localparam int ACC_W = ACC_BITS + $clog2(N_SPINS) + W_BITS;
  localparam int DW    = LANES * W_BITS;

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-ACC_BITS+1){1'b0}}, {(ACC_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, FETCH, ACC, DONE} state_t;

  state_t state, state_nxt;

  logic [BW-1:0]             beat;
  logic [RW-1:0]             row_q;
  logic [N_SPINS-1:0]        m_sh;
  logic signed [H_BITS-1:0]  h_q;
  logic signed [ACC_W-1:0]   acc, beat_sum, exact;
  logic [ACC_BITS-1:0]       out_q;
  logic                      ovf_q, vld_q, ready, accept, hi, lo;

  logic [DW-1:0]             mem [2**AW];
  logic [DW-1:0]             rd_q;
  logic [AW-1:0]             rd_addr;
  logic [LANES-1:0][TW-1:0]  term;

  assign accept = bus.start & ready;

  // During ACC the next beat is prefetched so each word lands as it is needed.
  assign rd_addr = AW'(row_q * BEATS + ((state == ACC) ? int'(beat) + 1 : 0));

  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    rd_q <= mem[rd_addr];
  end

  // Negation happens one bit wider so -(-2^(W_BITS-1)) stays exact.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [TW-1:0] jx;
    assign jx      = {rd_q[k*W_BITS+W_BITS-1], rd_q[k*W_BITS +: W_BITS]};
    assign term[k] = m_sh[k] ? jx : (~jx + 1'b1);
  end

  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < LANES; k++) beat_sum = beat_sum + ACC_W'($signed(term[k]));
  end

  assign exact = acc + ACC_W'(h_q);
  assign hi    = exact > MAXV;
  assign lo    = exact < MINV;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = FETCH;
      FETCH:   state_nxt = ACC;
      ACC:     if (beat == BW'(BEATS-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      m_sh  <= '0;
      h_q   <= '0;
      acc   <= '0;
      beat  <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          row_q <= bus.row;
          m_sh  <= bus.m_in;
          h_q   <= bus.h_in;
          acc   <= '0;
          beat  <= '0;
        end
        ACC: begin
          acc  <= acc + beat_sum;
          m_sh <= m_sh >> LANES;
          beat <= beat + 1'b1;
        end
        DONE: begin
          vld_q <= 1'b1;
          ovf_q <= hi | lo;
          if (SATURATE != 0 && hi)      out_q <= {1'b0, {(ACC_BITS-1){1'b1}}};
          else if (SATURATE != 0 && lo) out_q <= {1'b1, {(ACC_BITS-1){1'b0}}};
          else                          out_q <= exact[ACC_BITS-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.ready     = ready;
  assign bus.out_valid = vld_q;
  assign bus.out       = out_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: default build plus two 10-bit output builds
// (clamp and wrap) fed identical stimulus.
module tb_mac_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_seq_if #(.ACC_BITS(16)) b0 ();
  mac_seq_if #(.ACC_BITS(10)) b1 ();
  mac_seq_if #(.ACC_BITS(10)) b2 ();

  mac_seq #(.ACC_BITS(16), .SATURATE(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  mac_seq #(.ACC_BITS(10), .SATURATE(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mac_seq #(.ACC_BITS(10), .SATURATE(0)) u2 (.clk(clk), .rst(rst), .bus(b2));

  assign b2.wr_en   = b1.wr_en;
  assign b2.wr_addr = b1.wr_addr;
  assign b2.wr_data = b1.wr_data;
  assign b2.start   = b1.start;
  assign b2.row     = b1.row;
  assign b2.m_in    = b1.m_in;
  assign b2.h_in    = b1.h_in;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic wr0(input int addr, input logic [31:0] data);
    b0.wr_en = 1'b1; b0.wr_addr = addr[5:0]; b0.wr_data = data;
    @(posedge clk); #1;
    b0.wr_en = 1'b0;
  endtask

  task automatic wr1(input int addr, input logic [31:0] data);
    b1.wr_en = 1'b1; b1.wr_addr = addr[5:0]; b1.wr_data = data;
    @(posedge clk); #1;
    b1.wr_en = 1'b0;
  endtask

  // Start one run on u0 and wait for its result; latency counted from the accepting edge.
  task automatic run0(input int r, input logic [15:0] m, input int h,
                      input int exp_out, input int exp_ovf, input string tag);
    int lat;
    b0.row = r[3:0]; b0.m_in = m; b0.h_in = h[7:0]; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    chk({tag, "_rdy_lo"}, int'(b0.ready), 0);
    lat = 0;
    while (!b0.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, "_lat"}, lat, 6);
    chk({tag, "_out"}, int'($signed(b0.out)), exp_out);
    chk({tag, "_ovf"}, int'(b0.ovf), exp_ovf);
    chk({tag, "_rdy_hi"}, int'(b0.ready), 1);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, int'(b0.out_valid), 0);
  endtask

  initial begin
    int lat, n, first, last;
    b0.wr_en = 0; b0.wr_addr = '0; b0.wr_data = '0;
    b0.start = 0; b0.row = '0; b0.m_in = '0; b0.h_in = '0;
    b1.wr_en = 0; b1.wr_addr = '0; b1.wr_data = '0;
    b1.start = 0; b1.row = '0; b1.m_in = '0; b1.h_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready", int'(b0.ready), 1);
    chk("rst_valid", int'(b0.out_valid), 0);
    chk("rst_out", int'(b0.out), 0);
    chk("rst_ovf", int'(b0.ovf), 0);

    for (int b = 0; b < 4; b++) begin
      wr0(0 * 4 + b, {4{8'h01}});
      wr0(5 * 4 + b, {4{8'h05}});
      wr0(1 * 4 + b, {4{8'h80}});
      wr1(b, {4{8'h7F}});
    end

    run0(0, 16'hFFFF, 3, 19, 0, "r0");
    run0(5, 16'h5555, -2, -2, 0, "r5");
    run0(0, 16'hFFFF, 3, 19, 0, "r0_again");
    run0(1, 16'h0000, 0, 2048, 0, "r1_neg");

    // Exact 16*127+127 = 2159 against a 10-bit output.
    b1.row = '0; b1.m_in = 16'hFFFF; b1.h_in = 8'd127; b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    lat = 0;
    while (!b1.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("sat_lat", lat, 6);
    chk("sat_out", int'($signed(b1.out)), 511);
    chk("sat_ovf", int'(b1.ovf), 1);
    chk("wrap_valid", int'(b2.out_valid), 1);
    chk("wrap_out", int'($signed(b2.out)), 111);
    chk("wrap_ovf", int'(b2.ovf), 1);
    @(posedge clk); #1;

    // Extra start mid-run with different operands must be ignored.
    b0.row = 4'd0; b0.m_in = 16'hFFFF; b0.h_in = 8'd3; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    @(posedge clk); #1;
    b0.row = 4'd5; b0.m_in = 16'h0000; b0.h_in = 8'd100; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    chk("mid_rdy", int'(b0.ready), 0);
    lat = 2;
    while (!b0.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("mid_lat", lat, 6);
    chk("mid_out", int'($signed(b0.out)), 19);
    n = 0;
    repeat (15) begin @(posedge clk); #1; if (b0.out_valid) n++; end
    chk("mid_extra", n, 0);

    // Start held high: a new run is accepted in each out_valid cycle.
    b0.row = 4'd0; b0.m_in = 16'hFFFF; b0.h_in = 8'd3; b0.start = 1'b1;
    n = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (b0.out_valid) begin
        if (n == 0) chk("b2b_first", cyc, 6);
        else        chk("b2b_gap", cyc - last, 7);
        chk("b2b_out", int'($signed(b0.out)), 19);
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
    end
    chk("b2b_count", n, 4);
    b0.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    // Reset during cycle 3 of a run aborts it.
    b0.row = 4'd0; b0.m_in = 16'hFFFF; b0.h_in = 8'd3; b0.start = 1'b1;
    @(posedge clk); #1;
    b0.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_ready", int'(b0.ready), 1);
    chk("arst_out", int'(b0.out), 0);
    chk("arst_ovf", int'(b0.ovf), 0);
    chk("arst_valid", int'(b0.out_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    n = 0;
    repeat (10) begin @(posedge clk); #1; if (b0.out_valid) n++; end
    chk("arst_novalid", n, 0);
    run0(0, 16'hFFFF, 3, 19, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
